debug_ram_writer: RTL and testbench

Write-side front end for the 1024×8 debug RAM that the VGA debug display reads. It drives the RAM's port A, which the display leaves unused. After reset or on request it zero-fills the RAM. It then accepts a byte stream over a valid/ready handshake and stores the bytes at an auto-incrementing pointer that the user can reposition. Pointer layout matches the display, {row[5:0], col[3:0]}, so byte N appears at row N/16, column N%16.

---
 rtl/debug_ram_writer.sv | 113 +++++++++++
 tb/tb_debug_ram_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/debug_ram_writer.sv
// Write-side front end for the VGA debug RAM (port A). It zero-fills the RAM after
// reset or on request, then stores a valid/ready byte stream at an auto-incrementing pointer.
module debug_ram_writer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clear_req,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              wrapped
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] ptr;

  logic              xfer;
  logic [ADDR_W-1:0] wr_addr;

  // A set strobe that coincides with a transfer redirects that same byte.
  always_comb begin
    xfer    = 1'b0;
    wr_addr = ptr;
    if (state == RUN) begin
      xfer = in_valid && in_ready;
    end
    if (set_valid) begin
      wr_addr = set_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      ptr      <= '0;
      wrapped  <= 1'b0;
      ram_en   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (clear_req) begin
            clr_cnt <= '0;
            ram_en  <= 1'b0;
            ptr     <= '0;
            wrapped <= 1'b0;
          end else begin
            ram_en   <= 1'b1;
            ram_addr <= clr_cnt;
            ram_data <= '0;
            clr_cnt  <= clr_cnt + ADDR_W'(1);
            if (clr_cnt == '1) begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          // in_ready trails the state by one cycle, giving the 2^ADDR_W+1 fill length.
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (xfer) begin
            ram_en   <= 1'b1;
            ram_addr <= wr_addr;
            ram_data <= in_data;
            ptr      <= wr_addr + ADDR_W'(1);
            if (wr_addr == '1) begin
              wrapped <= 1'b1;
            end
          end else begin
            ram_en <= 1'b0;
            if (set_valid) begin
              ptr <= set_addr;
            end
          end
          if (clear_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            ptr      <= '0;
            wrapped  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ram_writer.sv
// Randomised bench for debug_ram_writer against a cycle-level behavioural model
// holding its own copy of the RAM contents.
module tb_debug_ram_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       set_valid;
  logic [9:0] set_addr;
  logic       clear_req;
  logic       ram_en;
  logic [9:0] ram_addr;
  logic [7:0] ram_data;
  logic       busy;
  logic       wrapped;

  debug_ram_writer #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .set_valid (set_valid),
    .set_addr  (set_addr),
    .clear_req (clear_req),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .busy      (busy),
    .wrapped   (wrapped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit  in_fill;
  int  fill_pos;
  int  mptr;
  bit  mwr;
  bit  e_en;
  int  e_addr;
  int  e_data;
  bit  e_rdy;
  bit  e_busy;
  byte unsigned ref_mem [1024];
  byte unsigned dut_mem [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit v, input logic [7:0] d, input bit sv,
                       input logic [9:0] sa, input bit cr, input bit rst);
    int a;
    if (rst) begin
      in_fill = 1'b1; fill_pos = 0; mptr = 0; mwr = 1'b0;
      e_en = 1'b0; e_addr = 0; e_data = 0; e_rdy = 1'b0; e_busy = 1'b1;
    end else if (in_fill) begin
      if (cr) begin
        fill_pos = 0; e_en = 1'b0;
      end else begin
        e_en = 1'b1; e_addr = fill_pos; e_data = 0;
        ref_mem[fill_pos] = 8'h00;
        fill_pos++;
        if (fill_pos == 1024) in_fill = 1'b0;
      end
    end else begin
      if (e_rdy && v) begin
        a = sv ? int'(sa) : mptr;
        e_en = 1'b1; e_addr = a; e_data = int'(d);
        ref_mem[a] = d;
        mptr = (a + 1) % 1024;
        if (a == 1023) mwr = 1'b1;
      end else begin
        e_en = 1'b0;
        if (sv) mptr = int'(sa);
      end
      e_rdy = 1'b1; e_busy = 1'b0;
      if (cr) begin
        in_fill = 1'b1; fill_pos = 0; mptr = 0; mwr = 1'b0;
        e_rdy = 1'b0; e_busy = 1'b1;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit sv,
                      input logic [9:0] sa, input bit cr, input bit rst);
    @(negedge clk);
    in_valid = v; in_data = d; set_valid = sv; set_addr = sa;
    clear_req = cr; rst_n = ~rst;
    @(posedge clk);
    model(v, d, sv, sa, cr, rst);
    #1;
    if (ram_en === 1'b1) dut_mem[ram_addr] = ram_data;
    check("cycle", {10'd0, ram_en, ram_addr, ram_data, in_ready, busy, wrapped},
          {10'd0, e_en, 10'(e_addr), 8'(e_data), e_rdy, e_busy, mwr});
  endtask

  task automatic fill_noise(input int n);
    for (int i = 0; i < n; i++) step(($urandom % 2) == 1, 8'($urandom), 1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic memcheck(input string tag);
    int diff = 0;
    for (int i = 0; i < 1024; i++) if (dut_mem[i] !== ref_mem[i]) diff++;
    check(tag, diff, 0);
  endtask

  initial begin
    int pulses;
    bit v, sv, cr;
    for (int i = 0; i < 1024; i++) begin
      dut_mem[i] = 8'($urandom);
      ref_mem[i] = 8'($urandom);
    end
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; set_valid = 1'b0;
    set_addr = '0; clear_req = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b1, 10'h3FF, 1'b1, 1'b1);
    check("reset", {ram_en, ram_addr, ram_data, in_ready, busy, wrapped}, {22'b0_0000000000_00000000_010});

    // Power-up fill
    pulses = 0;
    for (int i = 0; i < 1024; i++) begin
      step(($urandom % 2) == 1, 8'($urandom), 1'b0, 10'd0, 1'b0, 1'b0);
      if (ram_en === 1'b1) pulses++;
      if (i == 0) check("fill_first", ram_addr, 0);
    end
    check("fill_pulses", pulses, 1024);
    check("ready_1024", in_ready, 0);
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0);
    check("ready_1025", {in_ready, busy}, 2'b10);
    memcheck("mem_zero");

    // Streaming
    step(1'b1, 8'hA5, 1'b0, 10'd0, 1'b0, 1'b0); check("s0", {ram_en, ram_addr, ram_data}, {1'b1, 10'h000, 8'hA5});
    step(1'b1, 8'h5A, 1'b0, 10'd0, 1'b0, 1'b0); check("s1", {ram_en, ram_addr, ram_data}, {1'b1, 10'h001, 8'h5A});
    step(1'b1, 8'h3C, 1'b0, 10'd0, 1'b0, 1'b0); check("s2", {ram_en, ram_addr, ram_data}, {1'b1, 10'h002, 8'h3C});
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0); check("s_idle", ram_en, 0);

    // Pointer set and wrap
    step(1'b0, 8'h00, 1'b1, 10'h3FE, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 10'd0, 1'b0, 1'b0); check("p0", ram_addr, 10'h3FE); check("wrap_before", wrapped, 0);
    step(1'b1, 8'h22, 1'b0, 10'd0, 1'b0, 1'b0); check("p1", ram_addr, 10'h3FF); check("wrap_after", wrapped, 1);
    step(1'b1, 8'h33, 1'b0, 10'd0, 1'b0, 1'b0); check("p2", ram_addr, 10'h000);

    // Set together with a transfer
    step(1'b1, 8'h77, 1'b1, 10'h010, 1'b0, 1'b0); check("st0", {ram_addr, ram_data}, {10'h010, 8'h77});
    step(1'b1, 8'h88, 1'b0, 10'd0, 1'b0, 1'b0);  check("st1", {ram_addr, ram_data}, {10'h011, 8'h88});

    // Clear while a byte is accepted
    step(1'b0, 8'h00, 1'b1, 10'h005, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 10'd0, 1'b1, 1'b0);
    check("clr_wr", {ram_en, ram_addr, ram_data, in_ready, busy}, {1'b1, 10'h005, 8'h99, 2'b01});
    for (int i = 0; i < 1024; i++) step(1'b1, 8'($urandom), 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0);
    check("clr_done", {in_ready, busy, wrapped}, 3'b100);
    step(1'b1, 8'h42, 1'b0, 10'd0, 1'b0, 1'b0); check("clr_ptr", ram_addr, 0);
    memcheck("mem_clr");

    // Reset in the middle of a fill
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b1, 1'b0);
    fill_noise(501);
    check("mid_addr", ram_addr, 500);
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b1);
    check("mid_rst", {ram_en, ram_addr, ram_data, in_ready, busy, wrapped}, {22'b0_0000000000_00000000_010});
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0); check("mid_restart", {ram_en, ram_addr}, {1'b1, 10'h000});
    fill_noise(1024);
    memcheck("mem_mid");

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      v  = ($urandom % 4) != 0;
      sv = !in_fill && ($urandom % 12) == 0;
      cr = !in_fill && ($urandom % 600) == 0;
      step(v, 8'($urandom), sv, 10'($urandom), cr, 1'b0);
    end
    for (int i = 0; i < 1100 && !(e_rdy && !in_fill); i++) fill_noise(1);
    check("final_ready", in_ready, 1);
    memcheck("mem_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
